// File: rtl/mult_unit_pkg.sv
// rtl/mult_unit_pkg.sv - shared types and constants for the iterative multiplier
package mult_unit_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mult_state_e;

  // Read-path select codes the hazard detector uses to steer mfhi/mflo
  localparam logic [1:0] OUTSEL_HI = 2'b10;
  localparam logic [1:0] OUTSEL_LO = 2'b11;

endpackage

// File: rtl/mult_datapath.sv
// rtl/mult_datapath.sv - shift-add core: magnitude latch, accumulator, counter, sign fix-up
module mult_datapath
  import mult_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] raw;

  always_comb begin
    addend   = mplier_q[0] ? mcand_q : '0;
    sum      = acc_q + {1'b0, addend};
    // Final product includes this cycle's add, so it is ready on the last BUSY edge
    raw      = {sum, mplier_q[WIDTH-1:1]};
    product  = sign_q ? -raw : raw;
    last     = (cnt_q == CNT_W'(WIDTH - 1));

    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;

    if (start) begin
      mcand_d  = (signed_i && src_a[WIDTH-1]) ? -src_a : src_a;
      mplier_d = (signed_i && src_b[WIDTH-1]) ? -src_b : src_b;
      sign_d   = signed_i & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step) begin
      acc_d    = {1'b0, sum[WIDTH:1]};
      mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
    end
  end

endmodule

// File: rtl/mult_unit.sv
// rtl/mult_unit.sv - per-lane iterative multiplier with HI/LO registers and E-stage stall
module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_E,
  input  logic             multSigned_E,
  input  logic [WIDTH-1:0] srcA_E,
  input  logic [WIDTH-1:0] srcB_E,
  input  logic             flush_E,
  input  logic             hiWrite_E,
  input  logic             loWrite_E,
  input  logic [WIDTH-1:0] hiloData_E,
  output logic             multStall_E,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  mult_state_e        state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               start;
  logic               step;
  logic               last;
  logic [2*WIDTH-1:0] product;

  mult_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .rst      (reset),
    .start    (start),
    .step     (step),
    .signed_i (multSigned_E),
    .src_a    (srcA_E),
    .src_b    (srcB_E),
    .last     (last),
    .product  (product)
  );

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    start       = 1'b0;
    step        = 1'b0;
    multStall_E = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!flush_E) begin
          if (mult_E) begin
            start       = 1'b1;
            multStall_E = 1'b1;
            state_d     = ST_BUSY;
          end
          if (hiWrite_E) hi_d = hiloData_E;
          if (loWrite_E) lo_d = hiloData_E;
        end
      end
      ST_BUSY: begin
        multStall_E = 1'b1;
        // A flush abandons the operation; nothing partial reaches hi/lo
        if (flush_E) begin
          state_d = ST_IDLE;
        end else begin
          step = 1'b1;
          if (last) begin
            hi_d    = product[2*WIDTH-1:WIDTH];
            lo_d    = product[WIDTH-1:0];
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mult_unit.sv
// tb/tb_mult_unit.sv - self-checking bench for mult_unit
module tb_mult_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mult_E, multSigned_E, flush_E, hiWrite_E, loWrite_E;
  logic [31:0] srcA_E, srcB_E, hiloData_E;
  logic        multStall_E, busy;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[5];

  mult_unit dut (
    .clk          (clk),
    .reset        (reset),
    .mult_E       (mult_E),
    .multSigned_E (multSigned_E),
    .srcA_E       (srcA_E),
    .srcB_E       (srcB_E),
    .flush_E      (flush_E),
    .hiWrite_E    (hiWrite_E),
    .loWrite_E    (loWrite_E),
    .hiloData_E   (hiloData_E),
    .multStall_E  (multStall_E),
    .hi           (hi),
    .lo           (lo),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Issues one multiply from IDLE and follows it through DONE back to IDLE
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] ehi, input logic [31:0] elo, input string nm);
    int stall_cycles;
    logic [31:0] prev_hi, prev_lo;
    prev_hi = hi;
    prev_lo = lo;
    mult_E = 1'b1; multSigned_E = s; srcA_E = a; srcB_E = b;
    #1;
    chk({nm, " accept_stall"}, 64'(multStall_E), 64'd1);
    stall_cycles = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!multStall_E) break;
      if (stall_cycles == 32) begin
        chk({nm, " hi_held_busy"}, 64'(hi), 64'(prev_hi));
        chk({nm, " lo_held_busy"}, 64'(lo), 64'(prev_lo));
      end
      stall_cycles++;
      srcA_E = $urandom;
      srcB_E = $urandom;
    end
    chk({nm, " stall_cycles"}, 64'(stall_cycles), 64'd33);
    chk({nm, " hi"}, 64'(hi), 64'(ehi));
    chk({nm, " lo"}, 64'(lo), 64'(elo));
    chk({nm, " busy_done"}, 64'(busy), 64'd1);
    step();
    mult_E = 1'b0;
    #1;
    chk({nm, " idle_after_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] p;
    reset = 1'b1; mult_E = 0; multSigned_E = 0; flush_E = 0;
    hiWrite_E = 0; loWrite_E = 0; srcA_E = 0; srcB_E = 0; hiloData_E = 0;
    #12;
    chk("reset_stall", 64'(multStall_E), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    step();

    tbl[0] = '{32'd7,        32'd6,        1'b0, 32'h00000000, 32'h0000002A};
    tbl[1] = '{32'hFFFFFFFD, 32'd5,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1};
    tbl[2] = '{32'hFFFFFFFD, 32'd5,        1'b0, 32'h00000004, 32'hFFFFFFF1};
    tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
    tbl[4] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000};
    for (int i = 0; i < 5; i++)
      run_mult(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].hi, tbl[i].lo, $sformatf("tbl%0d", i));

    for (int i = 0; i < 16; i++) begin
      logic [31:0] a, b;
      logic s;
      a = $urandom; b = $urandom; s = 1'($urandom);
      if (i < 4) b = $urandom_range(0, 15);
      p = ref_prod(a, b, s);
      run_mult(a, b, s, p[63:32], p[31:0], $sformatf("rnd%0d", i));
    end

    // Flush at BUSY cycle 10 leaves prior hi/lo intact
    hiWrite_E = 1; loWrite_E = 1; hiloData_E = 32'h1234;
    step();
    loWrite_E = 0; hiWrite_E = 0;
    loWrite_E = 1; hiloData_E = 32'h5678;
    step();
    loWrite_E = 0;
    #1;
    chk("mthi_idle", 64'(hi), 64'h1234);
    chk("mtlo_idle", 64'(lo), 64'h5678);
    mult_E = 1; multSigned_E = 0; srcA_E = 32'd9; srcB_E = 32'd9;
    step();
    for (int i = 0; i < 10; i++) step();
    flush_E = 1;
    #1;
    chk("flush_busy_stall", 64'(multStall_E), 64'd1);
    step();
    flush_E = 0; mult_E = 0;
    #1;
    chk("flush_stall_drop", 64'(multStall_E), 64'd0);
    chk("flush_idle", 64'(busy), 64'd0);
    chk("flush_hi", 64'(hi), 64'h1234);
    chk("flush_lo", 64'(lo), 64'h5678);
    flush_E = 1; mult_E = 1;
    #1;
    chk("flush_idle_nostart", 64'(multStall_E), 64'd0);
    step();
    flush_E = 0; mult_E = 0;
    #1;
    chk("flush_idle_stays", 64'(busy), 64'd0);

    // mtlo then mult, with an mthi attempt during BUSY
    loWrite_E = 1; hiloData_E = 32'hDEADBEEF;
    step();
    loWrite_E = 0;
    mult_E = 1; multSigned_E = 0; srcA_E = 32'd2; srcB_E = 32'd3;
    step();
    hiWrite_E = 1; hiloData_E = 32'h55;
    for (int i = 0; i < 31; i++) step();
    chk("mtlo_held", 64'(lo), 64'hDEADBEEF);
    chk("mthi_busy_ignored", 64'(hi), 64'h1234);
    step();
    hiWrite_E = 0;
    #1;
    chk("mtlo_mult_lo", 64'(lo), 64'd6);
    chk("mtlo_mult_hi", 64'(hi), 64'd0);
    step();
    mult_E = 0;
    step();

    // Async reset in mid-operation
    run_mult(32'h00010000, 32'h00010000, 1'b0, 32'd1, 32'd0, "pre_reset");
    mult_E = 1; srcA_E = 32'd11; srcB_E = 32'd13;
    step();
    for (int i = 0; i < 5; i++) step();
    #2;
    reset = 1'b1; mult_E = 0;
    #1;
    chk("areset_stall", 64'(multStall_E), 64'd0);
    chk("areset_busy", 64'(busy), 64'd0);
    chk("areset_hi", 64'(hi), 64'd0);
    step();
    reset = 1'b0;
    step();
    run_mult(32'd11, 32'd13, 1'b0, 32'd0, 32'd143, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative 32x32 multiplier with HI/LO registers, one instance per execute lane of the dual-issue pipeline.
- Produces `multStall_E`, which the hazard detector uses to freeze its lane's E stage.
- Holds the instruction in E until the product is written, then releases it.
- Serves mfhi/mflo reads and mthi/mtlo writes for its lane.

Parameters:
- WIDTH, 32, operand width. The product is 2*WIDTH bits. One partial-product bit is retired per cycle.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mult_E  in  1  multiply instruction present in this lane's E stage
- multSigned_E  in  1  1 = signed multiply (mult), 0 = unsigned (multu)
- srcA_E  in  WIDTH  multiplicand (forwarded rs value)
- srcB_E  in  WIDTH  multiplier (forwarded rt value)
- flush_E  in  1  this lane's E-stage flush from the hazard detector
- hiWrite_E  in  1  mthi in E
- loWrite_E  in  1  mtlo in E
- hiloData_E  in  WIDTH  data for mthi/mtlo
- multStall_E  out  1  stall request to the hazard detector
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  state != IDLE (debug/observability)

Behaviour:
- Reset is asynchronous: state=IDLE, hi=0, lo=0, counter=0, internal accumulator=0.
  - Outputs at reset: multStall_E=0, busy=0.
- State machine has three states: IDLE, BUSY, DONE.
- IDLE:
  - If mult_E & ~flush_E: latch |srcA_E| and |srcB_E| (absolute values when multSigned_E=1).
  - Also latch the result sign = signed & (A[MSB]^B[MSB]), clear the accumulator and counter, go to BUSY.
- BUSY: each cycle:
  - Add the multiplicand to the accumulator high half if the multiplier LSB is 1.
  - Shift the {acc, multiplier} pair right by 1 and increment the counter.
  - When counter==WIDTH-1: form the final product, negating the 2*WIDTH result if the sign is set.
  - At that clock edge write hi=product[2W-1:W] and lo=product[W-1:0], then go to DONE.
- DONE: lasts one cycle, then returns to IDLE unconditionally.
  - mult_E is still high for the completing instruction; it must not restart the multiply.
- multStall_E is combinational: (IDLE & mult_E & ~flush_E) | BUSY.
  - It is asserted in the accept cycle plus WIDTH BUSY cycles, i.e. WIDTH+1 cycles total.
  - It is 0 in DONE, so the instruction leaves E while hi/lo already hold the result.
- flush_E in BUSY aborts the operation:
  - Next state is IDLE and multStall_E drops the following cycle.
  - hi and lo are unchanged; no partial result is ever written.
- flush_E in IDLE with mult_E high: no start.
- hiWrite_E / loWrite_E:
  - Honoured only in IDLE and when ~flush_E; they write hiloData_E at the edge.
  - Ignored in BUSY and DONE. The lane holds a single E instruction, so they cannot coincide with the mult in flight.
  - A product write in the final BUSY cycle always takes priority.
- If an external stall holds E, mult_E stays high: in BUSY the input operands are ignored (latched copies are used).
- Back-to-back mults: the second starts in the IDLE cycle after DONE.
  - Minimum spacing is WIDTH+2 cycles from accept to accept.
- hi and lo always present registered values. While BUSY they show the previous result.
  - Stalling mfhi/mflo readers against the multiply is the hazard detector's job via outSel.
- Reset asserted mid-operation returns immediately to IDLE and clears hi/lo.
- Counter width is clog2(WIDTH). Accumulator is WIDTH+1 bits to keep the carry.

Decomposition:
- Shared package holds:
  - state encoding typedef (IDLE=2'b00, BUSY=2'b01, DONE=2'b10);
  - WIDTH default;
  - the outSel encodings used for the hi/lo read path (2'b10 = HI, 2'b11 = LO).
- One natural sub-module: mult_datapath (accumulator, shifter, sign fix-up, counter). The FSM and hi/lo registers stay in mult_unit.

Test Plan:
- Unsigned 7*6:
  - Accept at cycle 0; multStall_E high for cycles 0..32, low in cycle 33 (DONE).
  - hi=0x00000000, lo=0x0000002A visible in DONE.
- Signed -3*5:
  - hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - Unsigned with the same bit patterns (0xFFFFFFFD*5): hi=0x00000004, lo=0xFFFFFFF1.
- Unsigned 0xFFFFFFFF*0xFFFFFFFF:
  - hi=0xFFFFFFFE, lo=0x00000001.
  - Signed 0x80000000*0x80000000: hi=0x40000000, lo=0.
- Flush at BUSY cycle 10 after prior hi=0x1234, lo=0x5678:
  - multStall_E low next cycle, state IDLE, hi/lo unchanged.
- mtlo 0xDEADBEEF in IDLE then mult 2*3:
  - lo reads 0xDEADBEEF until the final edge, then 6.
  - mthi attempted during BUSY is ignored.
- Async reset asserted at BUSY cycle 5:
  - Outputs go to zero without a clock edge.
  - A mult presented after reset release completes normally with correct hi/lo.
